// File: rtl/piece_move_controller_if.sv
// Checker handshake bundle between the move controller and a collision checker.
// The controller pulses checkEnable for one cycle with checkDir already stable;
// the checker answers on canMove in the following cycle, and the controller
// samples it exactly then. checkDir stays stable through that answer cycle.
// There is no back-pressure: the checker must always answer on time.
interface piece_move_controller_if;
  logic       checkEnable;
  logic [1:0] checkDir;
  logic       canMove;

  modport master (output checkEnable, output checkDir, input canMove);
  modport slave  (input checkEnable, input checkDir, output canMove);
endinterface

// File: rtl/piece_move_controller.sv
// Sequences left/right/gravity moves of the falling piece: latches requests
// into pending flags, arbitrates (down > left > right), runs one checker
// access per move and updates the piece origin only on a grant. A refused
// or out-of-range downward move produces a one-cycle lockPiece pulse.
module piece_move_controller #(
  parameter logic [3:0] SPAWN_X = 4'd6,
  parameter logic [4:0] SPAWN_Y = 5'd0,
  parameter logic [3:0] MAX_X   = 4'd12,
  parameter logic [4:0] MAX_Y   = 5'd16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [1:0]               spawnBlock,
  input  logic                     leftReq,
  input  logic                     rightReq,
  input  logic                     dropTick,
  piece_move_controller_if.master  chk,
  output logic [3:0]               XPOS,
  output logic [4:0]               YPOS,
  output logic [1:0]               currentBlock,
  output logic                     active,
  output logic                     lockPiece,
  output logic [2:0]               debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_ISSUE = 3'd2,
    S_EVAL  = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;

  state_t     state, state_nx;
  logic       pend_l, pend_r, pend_d;
  logic       clr_l, clr_r, clr_d, clr_all;
  logic       spawn, issue, apply;
  logic [1:0] dir_nx;

  // A piece is in play in READY/ISSUE/EVAL; only then are requests captured.
  assign active      = (state == S_READY) || (state == S_ISSUE) || (state == S_EVAL);
  assign lockPiece   = (state == S_LOCK);
  assign debug_state = state;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state, arbitration and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    clr_l    = 1'b0;
    clr_r    = 1'b0;
    clr_d    = 1'b0;
    clr_all  = 1'b0;
    spawn    = 1'b0;
    issue    = 1'b0;
    apply    = 1'b0;
    dir_nx   = DIR_LEFT;
    case (state)
      S_IDLE: begin
        if (Start) begin
          spawn    = 1'b1;
          clr_all  = 1'b1;
          state_nx = S_READY;
        end
      end
      S_READY: begin
        if (pend_d) begin
          clr_d = 1'b1;
          // Already on the floor: land without asking the checker.
          if (YPOS == MAX_Y) begin
            state_nx = S_LOCK;
          end else begin
            issue    = 1'b1;
            dir_nx   = DIR_DOWN;
            state_nx = S_ISSUE;
          end
        end else if (pend_l && pend_r) begin
          // Opposite requests cancel each other.
          clr_l = 1'b1;
          clr_r = 1'b1;
        end else if (pend_l) begin
          clr_l = 1'b1;
          if (XPOS != 4'd0) begin
            issue    = 1'b1;
            dir_nx   = DIR_LEFT;
            state_nx = S_ISSUE;
          end
        end else if (pend_r) begin
          clr_r = 1'b1;
          if (XPOS != MAX_X) begin
            issue    = 1'b1;
            dir_nx   = DIR_RIGHT;
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nx = S_EVAL;
      S_EVAL: begin
        state_nx = S_READY;
        if (chk.canMove)                 apply    = 1'b1;
        else if (chk.checkDir == DIR_DOWN) state_nx = S_LOCK;
      end
      S_LOCK: begin
        clr_all  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pending request flags; a new request beats a same-cycle clear.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      pend_d <= 1'b0;
    end else begin
      pend_l <= (pend_l & ~(clr_l | clr_all)) | (leftReq  & active);
      pend_r <= (pend_r & ~(clr_r | clr_all)) | (rightReq & active);
      pend_d <= (pend_d & ~(clr_d | clr_all)) | (dropTick & active);
    end
  end

  // Checker handshake: one-cycle enable, direction held until the next issue.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      chk.checkEnable <= 1'b0;
      chk.checkDir    <= DIR_LEFT;
    end else begin
      chk.checkEnable <= issue;
      if (issue) chk.checkDir <= dir_nx;
    end
  end

  // Piece origin and code: loaded on spawn, stepped only on a granted check.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      XPOS         <= 4'd0;
      YPOS         <= 5'd0;
      currentBlock <= 2'd0;
    end else if (spawn) begin
      XPOS         <= SPAWN_X;
      YPOS         <= SPAWN_Y;
      currentBlock <= spawnBlock;
    end else if (apply) begin
      case (chk.checkDir)
        DIR_LEFT:  XPOS <= XPOS - 4'd1;
        DIR_RIGHT: XPOS <= XPOS + 4'd1;
        DIR_DOWN:  YPOS <= YPOS + 5'd1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_controller.sv
// Bench for piece_move_controller: directed scenarios followed by random
// traffic, all compared every cycle against a move-level reference model.
module tb_piece_move_controller;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [1:0] spawnBlock;
  logic       leftReq, rightReq, dropTick;
  logic [3:0] XPOS;
  logic [4:0] YPOS;
  logic [1:0] currentBlock;
  logic       active, lockPiece;
  logic [2:0] debug_state;

  piece_move_controller_if bus ();

  piece_move_controller dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .spawnBlock   (spawnBlock),
    .leftReq      (leftReq),
    .rightReq     (rightReq),
    .dropTick     (dropTick),
    .chk          (bus),
    .XPOS         (XPOS),
    .YPOS         (YPOS),
    .currentBlock (currentBlock),
    .active       (active),
    .lockPiece    (lockPiece),
    .debug_state  (debug_state)
  );

  // Clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int grant_mode = 1;   // 0 refuse, 1 grant, 2 random

  // Scoreboard: directions of checker accesses the model expects, in order.
  logic [1:0] exp_q[$];

  // Reference model: piece in play, check progress and pending request sets.
  bit         m_play, m_landing;
  int         m_wait;          // 0 choosing, 1 checker enabled, 2 awaiting answer
  logic [1:0] m_dir, m_blk;
  logic [3:0] m_x;
  logic [4:0] m_y;
  bit         p_l, p_r, p_d;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_landing = 0; m_wait = 0; m_dir = 2'b00; m_blk = 2'b00;
    m_x = 4'd0; m_y = 5'd0; p_l = 0; p_r = 0; p_d = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit was_play, nl, nr, nd;
    was_play = m_play;
    nl = p_l; nr = p_r; nd = p_d;
    if (m_landing) begin
      m_landing = 0; nl = 0; nr = 0; nd = 0;
    end else if (!m_play) begin
      if (Start) begin
        m_play = 1; m_wait = 0; m_x = 4'd6; m_y = 5'd0; m_blk = spawnBlock;
        nl = 0; nr = 0; nd = 0;
      end
    end else if (m_wait == 0) begin
      if (p_d) begin
        nd = 0;
        if (m_y == 5'd16) begin m_play = 0; m_landing = 1; end
        else begin m_dir = 2'b10; m_wait = 1; exp_q.push_back(2'b10); end
      end else if (p_l && p_r) begin
        nl = 0; nr = 0;
      end else if (p_l) begin
        nl = 0;
        if (m_x != 4'd0) begin m_dir = 2'b00; m_wait = 1; exp_q.push_back(2'b00); end
      end else if (p_r) begin
        nr = 0;
        if (m_x != 4'd12) begin m_dir = 2'b01; m_wait = 1; exp_q.push_back(2'b01); end
      end
    end else if (m_wait == 1) begin
      m_wait = 2;
    end else begin
      m_wait = 0;
      if (bus.canMove) begin
        if (m_dir == 2'b00)      m_x = m_x - 4'd1;
        else if (m_dir == 2'b01) m_x = m_x + 4'd1;
        else                     m_y = m_y + 5'd1;
      end else if (m_dir == 2'b10) begin
        m_play = 0; m_landing = 1;
      end
    end
    if (was_play) begin
      nl = nl | leftReq; nr = nr | rightReq; nd = nd | dropTick;
    end
    p_l = nl; p_r = nr; p_d = nd;
  endtask

  task automatic compare_all();
    chk("checkEnable", 8'(bus.checkEnable), 8'(m_play && m_wait == 1));
    chk("checkDir", 8'(bus.checkDir), 8'(m_dir));
    chk("XPOS", 8'(XPOS), 8'(m_x));
    chk("YPOS", 8'(YPOS), 8'(m_y));
    chk("currentBlock", 8'(currentBlock), 8'(m_blk));
    chk("active", 8'(active), 8'(m_play));
    chk("lockPiece", 8'(lockPiece), 8'(m_landing));
    if (bus.checkEnable === 1'b1) begin
      chk("check_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) chk("check_dir_order", 8'(bus.checkDir), 8'(exp_q.pop_front()));
    end
  endtask

  // Driver: one clock, model advance, sample #1 after the edge, checker answer.
  task automatic tick();
    @(posedge Clock);
    if (Reset) model_reset();
    else       model_step();
    #1;
    compare_all();
    if (m_play && m_wait == 2) begin
      if (grant_mode == 2) bus.canMove = 1'($urandom_range(0, 1));
      else                 bus.canMove = (grant_mode == 1);
    end else begin
      bus.canMove = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run(input int n, output int ce, output int lk);
    ce = 0; lk = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      ce += int'(bus.checkEnable);
      lk += int'(lockPiece);
    end
  endtask

  task automatic pulse(input bit l, input bit r, input bit d);
    leftReq = l; rightReq = r; dropTick = d;
    tick();
    leftReq = 0; rightReq = 0; dropTick = 0;
  endtask

  task automatic spawn(input logic [1:0] blk);
    spawnBlock = blk; Start = 1;
    tick();
    Start = 0;
  endtask

  initial begin
    int ce, lk;
    Reset = 1; Start = 0; spawnBlock = 0;
    leftReq = 0; rightReq = 0; dropTick = 0; bus.canMove = 0;
    model_reset();
    run(3, ce, lk);
    chk("reset_state_idle", 8'(active), 8'd0);
    Reset = 0;
    run(2, ce, lk);

    // Spawn, then a second Start while active is ignored.
    spawn(2'b10);
    chk("spawn_x", 8'(XPOS), 8'd6);
    chk("spawn_y", 8'(YPOS), 8'd0);
    chk("spawn_block", 8'(currentBlock), 8'd2);
    chk("spawn_active", 8'(active), 8'd1);
    spawn(2'b01);
    chk("restart_ignored", 8'(currentBlock), 8'd2);

    // Refused left: no movement, no lock.
    grant_mode = 0;
    pulse(1, 0, 0);
    run(4, ce, lk);
    chk("left_refused_x", 8'(XPOS), 8'd6);
    chk("left_refused_lock", 8'(lk), 8'd0);

    // Granted left with exact latency.
    grant_mode = 1;
    pulse(1, 0, 0);                       // now in N+1
    tick(); chk("left_ce_n2", 8'(bus.checkEnable), 8'd1);
    chk("left_dir_n2", 8'(bus.checkDir), 8'd0);
    tick(); chk("left_ce_n3", 8'(bus.checkEnable), 8'd0);
    chk("left_x_n3", 8'(XPOS), 8'd6);
    tick(); chk("left_x_n4", 8'(XPOS), 8'd5);

    // Right back to 6, then all three requests at once.
    pulse(0, 1, 0);
    run(4, ce, lk);
    chk("right_x", 8'(XPOS), 8'd6);
    pulse(1, 1, 1);
    run(12, ce, lk);
    chk("arb_one_check", 8'(ce), 8'd1);
    chk("arb_y", 8'(YPOS), 8'd1);
    chk("arb_x", 8'(XPOS), 8'd6);

    // Left wall.
    for (int i = 0; i < 6; i++) begin pulse(1, 0, 0); run(4, ce, lk); end
    chk("wall_x0", 8'(XPOS), 8'd0);
    pulse(1, 0, 0);
    run(6, ce, lk);
    chk("wall_no_check", 8'(ce), 8'd0);
    chk("wall_x_stays", 8'(XPOS), 8'd0);

    // Floor: step down to 16, then a drop locks without a check.
    for (int i = 0; i < 15; i++) begin pulse(0, 0, 1); run(4, ce, lk); end
    chk("floor_y16", 8'(YPOS), 8'd16);
    pulse(0, 0, 1);
    run(6, ce, lk);
    chk("floor_no_check", 8'(ce), 8'd0);
    chk("floor_one_lock", 8'(lk), 8'd1);
    chk("floor_idle", 8'(active), 8'd0);

    // Landing on a refused drop; later lefts are ignored.
    spawn(2'b11);
    grant_mode = 0;
    pulse(0, 0, 1);
    run(6, ce, lk);
    chk("land_one_lock", 8'(lk), 8'd1);
    chk("land_inactive", 8'(active), 8'd0);
    pulse(1, 0, 0); pulse(1, 0, 0);
    run(6, ce, lk);
    chk("land_ignored_ce", 8'(ce), 8'd0);
    chk("land_ignored_x", 8'(XPOS), 8'd6);

    // Asynchronous reset while the checker is enabled.
    grant_mode = 1;
    spawn(2'b01);
    pulse(1, 0, 0);
    tick();
    chk("pre_reset_ce", 8'(bus.checkEnable), 8'd1);
    Reset = 1;
    #1;
    model_reset();
    compare_all();
    chk("async_ce", 8'(bus.checkEnable), 8'd0);
    chk("async_x", 8'(XPOS), 8'd0);
    chk("async_lock", 8'(lockPiece), 8'd0);
    run(2, ce, lk);
    chk("reset_no_lock", 8'(lk), 8'd0);
    Reset = 0;

    // Random traffic.
    grant_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      Start      = ($urandom_range(0, 7) == 0);
      spawnBlock = 2'($urandom_range(0, 3));
      leftReq    = ($urandom_range(0, 5) == 0);
      rightReq   = ($urandom_range(0, 5) == 0);
      dropTick   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 599) == 0) begin
        Reset = 1;
        #1;
        model_reset();
        compare_all();
        tick();
        Reset = 0;
      end else begin
        tick();
      end
    end
    Start = 0; leftReq = 0; rightReq = 0; dropTick = 0;
    run(8, ce, lk);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/piece_move_controller.md
# piece_move_controller

Sequences every move of the active falling piece. Latches left/right/gravity requests, arbitrates between them, and drives a registered collision checker through an enable/direction handshake. Updates the piece origin (XPOS, YPOS) only when the checker grants the move, and issues a one-cycle lock pulse when a downward move is refused. Sits between the input/gravity-timer logic and the per-direction collision checkers (left, right and down), and owns the piece position seen by the board and renderer.

## Interface
- SPAWN_X, 6: XPOS loaded on spawn (4-bit).
- SPAWN_Y, 0: YPOS loaded on spawn (5-bit).
- MAX_X, 12: largest legal XPOS.
- MAX_Y, 16: largest legal YPOS; the piece occupies rows YPOS..YPOS+3 of the 20-row board.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Start  in  1  one-cycle pulse: spawn a new piece. Honoured only in IDLE.
- spawnBlock  in  2  piece code latched on Start.
- leftReq, rightReq  in  1 each  one-cycle move pulses from input logic.
- dropTick  in  1  one-cycle gravity pulse.
- canMove  in  1  checker result, valid the cycle after checkEnable.
- checkEnable  out  1  registered; enables the checker for exactly one cycle per check.
- checkDir  out  2  registered direction select: 00 = left, 01 = right, 10 = down. Held stable from ISSUE through EVAL.
- XPOS  out  4  piece origin column.
- YPOS  out  5  piece origin row.
- currentBlock  out  2  latched piece code.
- active  out  1  high while a piece is in play (READY/ISSUE/EVAL).
- lockPiece  out  1  one-cycle pulse: piece has landed and the board must absorb it.

## Operation
- States: IDLE, READY, ISSUE, EVAL, LOCK.
- IDLE:
  - On Start: load XPOS=SPAWN_X, YPOS=SPAWN_Y, currentBlock=spawnBlock, clear all pending flags, go to READY.
  - Other inputs are ignored.
- Pending flags pendL, pendR, pendD:
  - Each is set at any edge where its request is high and the FSM is not in IDLE or LOCK.
  - A set in the same cycle as a clear wins.
- READY: select by priority, down > left > right.
  - If pendL and pendR are both set and pendD is clear, clear both and stay in READY (the inputs cancel).
  - Down selected and YPOS==MAX_Y: clear pendD and go to LOCK without a checker access.
  - Left selected with XPOS==0, or right selected with XPOS==MAX_X: clear that flag and stay in READY. No checker access.
  - Otherwise: clear the selected flag, register checkDir, go to ISSUE.
- ISSUE: checkEnable=1 for this one cycle; go to EVAL.
- EVAL: sample canMove.
  - canMove=1: left gives XPOS-1, right gives XPOS+1, down gives YPOS+1. Go to READY.
  - canMove=0 with down: go to LOCK.
  - canMove=0 with left or right: no change, go to READY.
- LOCK: lockPiece=1 for one cycle, clear all pending flags, go to IDLE.
- Width rules:
  - XPOS and YPOS never wrap. The bound checks in READY guarantee XPOS stays in 0..MAX_X and YPOS in 0..MAX_Y.
  - Position changes only in EVAL or on spawn.
- Start outside IDLE is ignored. No queueing.

## Timing
- Reset values: state=IDLE, XPOS=0, YPOS=0, currentBlock=0, checkEnable=0, checkDir=00, active=0, lockPiece=0, all pending flags=0.
- Reset mid-check returns to IDLE immediately. No lockPiece is issued and checkEnable drops asynchronously.
- Spawn: Start in cycle N gives XPOS/YPOS/active valid in cycle N+1.
- Move latency: request in cycle N with the FSM idle in READY gives:
  - pending set at edge N;
  - ISSUE in N+2 (checkEnable high);
  - EVAL in N+3;
  - updated position visible in N+4.
- Throughput: one check per 3 cycles (READY, ISSUE, EVAL). Requests arriving meanwhile are held in the pending flags. Repeats of the same type merge into one.
- lockPiece: asserted 1 cycle after the refusing EVAL. active falls in the same cycle lockPiece rises.

## Test plan
- Spawn: Reset, then Start with spawnBlock=2'b10 -> next cycle XPOS=6, YPOS=0, currentBlock=10, active=1. A second Start while active -> no change.
- Left move: leftReq in cycle N, canMove=1 -> checkEnable high only in N+2 with checkDir=00; XPOS=5 in N+4. Repeat with canMove=0 -> XPOS stays 6, lockPiece stays 0.
- Arbitration: leftReq, rightReq and dropTick in the same cycle -> one down check only, then left and right both cancelled. With canMove=1, YPOS=1 and XPOS=6.
- Bounds: drive left moves until XPOS=0, then leftReq -> checkEnable never asserts and XPOS stays 0. At YPOS=16, dropTick -> lockPiece pulse with no checkEnable, then IDLE.
- Landing: dropTick with canMove=0 in EVAL -> lockPiece high exactly one cycle, active=0, and later leftReq pulses are ignored until the next Start.
- Reset mid-operation: assert Reset while in ISSUE -> checkEnable=0 and all outputs at reset values immediately; no lockPiece.
